// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_pkg
// Description : Shared definitions for the LDPC decoder datapath: the
//               accumulator state encoding, default datapath widths and a
//               pair of helpers giving the signed clamp limits for a width.
// Revision    : 1.0 - initial release
// ============================================================================
package ldpc_pkg;

  // Accumulator frame state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int W_DEF     = 6;
  localparam int ACC_W_DEF = 9;
  localparam int OUT_W_DEF = 6;

  // Largest positive value of an n-bit signed number
  function automatic int signed_max(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  // Most negative allowed value of an n-bit signed number; the symmetric
  // range excludes the lone -2^(n-1) code so that |min| == max.
  function automatic int signed_min(input int n, input bit sym);
    return sym ? -((1 << (n - 1)) - 1) : -(1 << (n - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : ripple_adder_n
// Description : N-bit ripple-carry adder built from a chain of full adders,
//               with carry in, carry out and signed overflow.
// Ports       : a, b  - N-bit addends
//               cin   - carry into bit 0
//               sum   - N-bit sum
//               cout  - carry out of the MSB
//               ovf   - signed overflow (carry into MSB != carry out of MSB)
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_adder_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  // Carry is threaded through the loop as a variable so the chain stays a
  // single combinational process rather than a self-referencing vector.
  always_comb begin
    logic w_c;
    logic w_c_msb;
    w_c     = cin;
    w_c_msb = 1'b0;
    sum     = '0;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        w_c_msb = w_c;
      end
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
    ovf  = w_c ^ w_c_msb;
  end

endmodule
`default_nettype wire

// File: rtl/llr_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : llr_accumulator
// Description : Handshaked saturating accumulator summing a frame of signed
//               LLR messages (one per cycle) into an ACC_W register, then
//               presenting a clamped OUT_W result with status flags.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_valid/in_ready    - operand handshake
//               in_data, in_last     - signed operand, end-of-frame marker
//               out_valid/out_ready  - result handshake
//               out_sum              - saturated signed sum
//               out_sat              - saturation seen in this frame
//               out_count            - operands accepted, clamped at MAX_OPS
//               out_err              - frame longer than MAX_OPS
// Revision    : 1.0 - initial release
// ============================================================================
module llr_accumulator
  import ldpc_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SYM     = 1,
  parameter int MAX_OPS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [W-1:0]                     in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_W-1:0]                 out_sum,
  output logic                             out_sat,
  output logic [$clog2(MAX_OPS+1)-1:0]     out_count,
  output logic                             out_err
);

  localparam int CNT_W = $clog2(MAX_OPS + 1);

  localparam logic signed [ACC_W-1:0] c_ACC_MAX = ACC_W'(signed_max(ACC_W));
  localparam logic signed [ACC_W-1:0] c_ACC_MIN = ACC_W'(signed_min(ACC_W, SYM != 0));
  localparam logic signed [ACC_W-1:0] c_OUT_MAX = ACC_W'(signed_max(OUT_W));
  localparam logic signed [ACC_W-1:0] c_OUT_MIN = ACC_W'(signed_min(OUT_W, SYM != 0));
  localparam logic [CNT_W-1:0]        c_CNT_MAX = CNT_W'(MAX_OPS);

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sat;
  logic                     r_err;

  logic [OUT_W-1:0]         r_out_sum;
  logic                     r_out_sat;
  logic [CNT_W-1:0]         r_out_count;
  logic                     r_out_err;

  logic                     w_accept;
  logic signed [ACC_W-1:0]  w_opnd;
  logic [ACC_W-1:0]         w_sum;
  logic                     w_ovf;
  logic                     w_unused_cout;

  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     w_sat_nxt;
  logic                     w_err_nxt;
  logic [OUT_W-1:0]         w_out_sum;
  logic                     w_out_clip;

  assign w_accept = in_valid & in_ready;
  assign w_opnd   = ACC_W'($signed(in_data));

  ripple_adder_n #(
    .N    (ACC_W)
  ) u_adder (
    .a    (r_acc),
    .b    (w_opnd),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_unused_cout),
    .ovf  (w_ovf)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        if (w_accept) begin
          w_state_nxt = in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (r_state == ST_HOLD) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulate path. The first operand of a frame loads the register and
  // clears the per-frame flags; later operands go through the saturating add.
  // On overflow both addends share a sign, so the accumulator sign picks the
  // clamp direction.
  // --------------------------------------------------------------------------
  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    w_err_nxt = r_err;
    if (r_state == ST_IDLE) begin
      w_acc_nxt = w_opnd;
      w_cnt_nxt = CNT_W'(1);
      w_sat_nxt = 1'b0;
      w_err_nxt = 1'b0;
    end else begin
      if (w_ovf) begin
        w_acc_nxt = r_acc[ACC_W-1] ? c_ACC_MIN : c_ACC_MAX;
      end else begin
        w_acc_nxt = $signed(w_sum);
      end
      w_sat_nxt = r_sat | w_ovf;
      if (r_cnt == c_CNT_MAX) begin
        w_err_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Output reduction of the value about to be stored. With a symmetric range
  // the comparison against c_OUT_MIN also catches the -2^(OUT_W-1) code.
  always_comb begin
    w_out_clip = 1'b0;
    w_out_sum  = w_acc_nxt[OUT_W-1:0];
    if (w_acc_nxt > c_OUT_MAX) begin
      w_out_sum  = c_OUT_MAX[OUT_W-1:0];
      w_out_clip = 1'b1;
    end else if (w_acc_nxt < c_OUT_MIN) begin
      w_out_sum  = c_OUT_MIN[OUT_W-1:0];
      w_out_clip = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers. Result registers load only on the accept that ends
  // the frame, so they hold steady through any output backpressure.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_err       <= 1'b0;
      r_out_sum   <= '0;
      r_out_sat   <= 1'b0;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
      r_err <= w_err_nxt;
      if (in_last) begin
        r_out_sum   <= w_out_sum;
        r_out_sat   <= w_sat_nxt | w_out_clip;
        r_out_count <= w_cnt_nxt;
        r_out_err   <= w_err_nxt;
      end
    end
  end

  assign out_sum   = r_out_sum;
  assign out_sat   = r_out_sat;
  assign out_count = r_out_count;
  assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_llr_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_llr_accumulator
// Description : Self-checking bench for llr_accumulator. Two instances share
//               one stimulus stream: one with the symmetric clamp range and
//               one with the full two's-complement range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llr_accumulator;

  localparam int W       = 6;
  localparam int ACC_W   = 9;
  localparam int OUT_W   = 6;
  localparam int MAX_OPS = 16;
  localparam int CNT_W   = $clog2(MAX_OPS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_ready;

  logic             rdy_s, vld_s, sat_s, err_s;
  logic [OUT_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_s;
  logic             rdy_a, vld_a, sat_a, err_a;
  logic [OUT_W-1:0] sum_a;
  logic [CNT_W-1:0] cnt_a;

  int checks   = 0;
  int failures = 0;
  int ops[$];

  always #5 clk = ~clk;

  llr_accumulator #(
    .W (W), .ACC_W (ACC_W), .OUT_W (OUT_W), .SYM (1), .MAX_OPS (MAX_OPS)
  ) u_sym (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (rdy_s), .in_data (in_data), .in_last (in_last),
    .out_valid (vld_s), .out_ready (out_ready), .out_sum (sum_s),
    .out_sat (sat_s), .out_count (cnt_s), .out_err (err_s)
  );

  llr_accumulator #(
    .W (W), .ACC_W (ACC_W), .OUT_W (OUT_W), .SYM (0), .MAX_OPS (MAX_OPS)
  ) u_asym (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (rdy_a), .in_data (in_data), .in_last (in_last),
    .out_valid (vld_a), .out_ready (out_ready), .out_sum (sum_a),
    .out_sat (sat_a), .out_count (cnt_a), .out_err (err_a)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the whole frame in ops[].
  function automatic void model(input bit sym, output int es, output int esat,
                                output int ec, output int eerr);
    int acc, s, amax, amin_tc, amin, omax, omin;
    amax    = (1 << (ACC_W - 1)) - 1;
    amin_tc = -(1 << (ACC_W - 1));
    amin    = sym ? -amax : amin_tc;
    omax    = (1 << (OUT_W - 1)) - 1;
    omin    = sym ? -omax : -(1 << (OUT_W - 1));
    acc  = 0;
    esat = 0;
    foreach (ops[i]) begin
      if (i == 0) begin
        acc = ops[i];
      end else begin
        s = acc + ops[i];
        if (s > amax) begin
          acc = amax; esat = 1;
        end else if (s < amin_tc) begin
          acc = amin; esat = 1;
        end else begin
          acc = s;
        end
      end
    end
    ec   = (ops.size() > MAX_OPS) ? MAX_OPS : ops.size();
    eerr = (ops.size() > MAX_OPS) ? 1 : 0;
    if (acc > omax) begin
      es = omax; esat = 1;
    end else if (acc < omin) begin
      es = omin; esat = 1;
    end else begin
      es = acc;
    end
  endfunction

  task automatic check_result(input string tag);
    int es, esat, ec, eerr;
    model(1'b1, es, esat, ec, eerr);
    chk({tag, ":s.valid"}, vld_s, 1);
    chk({tag, ":s.ready"}, rdy_s, 0);
    chk({tag, ":s.sum"},   $signed(sum_s), es);
    chk({tag, ":s.sat"},   sat_s, esat);
    chk({tag, ":s.count"}, cnt_s, ec);
    chk({tag, ":s.err"},   err_s, eerr);
    model(1'b0, es, esat, ec, eerr);
    chk({tag, ":a.valid"}, vld_a, 1);
    chk({tag, ":a.ready"}, rdy_a, 0);
    chk({tag, ":a.sum"},   $signed(sum_a), es);
    chk({tag, ":a.sat"},   sat_a, esat);
    chk({tag, ":a.count"}, cnt_a, ec);
    chk({tag, ":a.err"},   err_a, eerr);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ":s.valid"}, vld_s, 0);
    chk({tag, ":s.ready"}, rdy_s, 1);
    chk({tag, ":a.valid"}, vld_a, 0);
    chk({tag, ":a.ready"}, rdy_a, 1);
  endtask

  // Drive ops[] as one frame, check the result, hold it for 'hold' cycles
  // while offering junk operands, then complete the output handshake.
  task automatic run_frame(input string tag, input int hold, input bit gaps);
    foreach (ops[i]) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
        @(negedge clk);
      end
      chk({tag, ":in_ready"}, rdy_s & rdy_a, 1);
      in_valid = 1'b1;
      in_data  = W'(ops[i]);
      in_last  = (i == ops.size() - 1);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = W'($urandom);
    in_last  = 1'($urandom);
    check_result(tag);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_data = W'($urandom);
      in_last = 1'($urandom);
      check_result({tag, ":hold"});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check_idle({tag, ":after"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mode, v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset:sum",   {sum_s, sum_a}, 0);
    chk("reset:sat",   {sat_s, sat_a}, 0);
    chk("reset:count", {cnt_s, cnt_a}, 0);
    chk("reset:err",   {err_s, err_a}, 0);
    check_idle("reset");
    rst = 1'b0;

    ops = '{5, -3, 10};          run_frame("basic", 0, 1'b0);
    ops = '{31, 31, 31};         run_frame("outclamp", 1, 1'b0);
    ops = '{-32};                run_frame("neg32", 0, 1'b0);
    ops.delete();
    for (int i = 0; i < 17; i++) ops.push_back(31);
    run_frame("accovf17", 0, 1'b0);
    ops.delete();
    for (int i = 0; i < 17; i++) ops.push_back(-32);
    run_frame("accneg17", 0, 1'b0);
    ops = '{7};                  run_frame("backpressure", 5, 1'b0);
    ops = '{-4};                 run_frame("after_bp", 0, 1'b0);

    // Reset mid-frame discards the partial sum
    @(negedge clk);
    in_valid = 1'b1; in_data = W'(20); in_last = 1'b0;
    @(negedge clk);
    in_data = W'(20);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_idle("midreset");
      @(negedge clk);
    end
    ops = '{1};                  run_frame("post_reset", 0, 1'b0);

    // Randomized frames, some biased toward saturation and some overlong
    for (int f = 0; f < 40; f++) begin
      ops.delete();
      n    = $urandom_range(1, 20);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        case (mode)
          0:       v = int'($urandom_range(0, 63)) - 32;
          1:       v = $urandom_range(18, 31);
          default: v = -int'($urandom_range(18, 32));
        endcase
        ops.push_back(v);
      end
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
